// File: rtl/ex_mod_krr_keyring_if.sv
// Issue/result bundle between the EX stage and the keyring unit.
// Handshake: an op is accepted on every rising edge where i_valid=1 and i_hold=0; there is
// no backpressure, and o_valid flags a result registered one accepted edge later.
interface ex_mod_krr_keyring_if #(
  parameter int DATA_W   = 64,
  parameter int NUM_KEYS = 4,
  parameter int SLOT_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
);
  logic                i_valid;
  logic [1:0]          i_op;
  logic [SLOT_W-1:0]   i_slot;
  logic                i_hold;
  logic [DATA_W-1:0]   i_dlr;
  logic [DATA_W-1:0]   i_dhr;
  logic                o_valid;
  logic [DATA_W+1:0]   o_dlr_e;
  logic [DATA_W+1:0]   o_dhr_e;
  logic [NUM_KEYS-1:0] o_lock;

  modport master (
    output i_valid, i_op, i_slot, i_hold, i_dlr, i_dhr,
    input  o_valid, o_dlr_e, o_dhr_e, o_lock
  );

  modport slave (
    input  i_valid, i_op, i_slot, i_hold, i_dlr, i_dhr,
    output o_valid, o_dlr_e, o_dhr_e, o_lock
  );
endinterface

// File: rtl/ex_mod_krr_keyring.sv
// Multi-slot keyring encode/decode unit for the EX stage: XOR keys, folded parity check,
// per-slot decode failure counting with lockout. One-cycle registered latency, honours hold.
module ex_mod_krr_keyring #(
  parameter int DATA_W   = 64,
  parameter int PAR_W    = 16,
  parameter int NUM_KEYS = 4,
  parameter int MAX_FAIL = 3,
  parameter int SLOT_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input logic                 clock,
  input logic                 reset,
  ex_mod_krr_keyring_if.slave bus
);
  localparam int         NCHUNK  = DATA_W / PAR_W;
  localparam logic [3:0] MAX_CNT = 4'(MAX_FAIL);

  typedef enum logic [1:0] {
    OP_LDKEY  = 2'b00,
    OP_DEC    = 2'b01,
    OP_ENC    = 2'b10,
    OP_CLRKEY = 2'b11
  } op_e;

  logic [DATA_W-1:0]   key      [NUM_KEYS];
  logic [3:0]          fail_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] lock;
  logic                valid_q;
  logic [DATA_W+1:0]   dlr_q;
  logic [DATA_W+1:0]   dhr_q;

  logic [NUM_KEYS-1:0] slot_hit;
  logic [DATA_W-1:0]   sel_key;
  logic [3:0]          sel_cnt;
  logic                sel_lock;
  logic [DATA_W-1:0]   data_x;
  logic [PAR_W-1:0]    par_x;
  logic [PAR_W-1:0]    enc_par;
  logic                key_en;
  logic                dec_ok;
  logic [3:0]          cnt_next;
  op_e                 op;
  logic                unused_dhr_hi;

  function automatic logic [PAR_W-1:0] fold(input logic [DATA_W-1:0] x);
    logic [PAR_W-1:0] f;
    f = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      f = f ^ x[c*PAR_W +: PAR_W];
    end
    return f;
  endfunction

  // Out-of-range slots match no entry, so they read as a zero (disabled), unlocked key.
  always_comb begin
    slot_hit = '0;
    sel_key  = '0;
    sel_cnt  = '0;
    sel_lock = 1'b0;
    for (int s = 0; s < NUM_KEYS; s++) begin
      if (bus.i_slot == SLOT_W'(s)) begin
        slot_hit[s] = 1'b1;
        sel_key     = key[s];
        sel_cnt     = fail_cnt[s];
        sel_lock    = lock[s];
      end
    end
    op       = op_e'(bus.i_op);
    data_x   = bus.i_dlr ^ sel_key;
    par_x    = bus.i_dhr[PAR_W-1:0] ^ sel_key[PAR_W-1:0];
    enc_par  = fold(bus.i_dlr) ^ sel_key[PAR_W-1:0];
    key_en   = |sel_key[3:0];
    dec_ok   = key_en && (fold(data_x) == par_x);
    cnt_next = (sel_cnt < MAX_CNT) ? sel_cnt + 4'd1 : sel_cnt;
  end

  assign unused_dhr_hi = ^bus.i_dhr[DATA_W-1:PAR_W];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_KEYS; s++) begin
        key[s]      <= '0;
        fail_cnt[s] <= '0;
      end
      lock    <= '0;
      valid_q <= 1'b0;
      dlr_q   <= '0;
      dhr_q   <= '0;
    end else if (!bus.i_hold) begin
      valid_q <= bus.i_valid;
      dlr_q   <= '0;
      dhr_q   <= '0;
      if (bus.i_valid) begin
        unique case (op)
          OP_LDKEY: begin
            dlr_q <= {2'b00, bus.i_dlr};
            for (int s = 0; s < NUM_KEYS; s++) begin
              if (slot_hit[s]) begin
                key[s]      <= bus.i_dlr;
                fail_cnt[s] <= '0;
                lock[s]     <= 1'b0;
              end
            end
          end
          OP_CLRKEY: begin
            for (int s = 0; s < NUM_KEYS; s++) begin
              if (slot_hit[s]) begin
                key[s]      <= '0;
                fail_cnt[s] <= '0;
                lock[s]     <= 1'b0;
              end
            end
          end
          OP_ENC: begin
            if (!sel_lock) begin
              dlr_q <= {2'b00, data_x};
              dhr_q <= (DATA_W+2)'(enc_par);
            end
          end
          OP_DEC: begin
            // A locked slot yields zero and stops counting until reloaded or cleared.
            if (!sel_lock) begin
              if (dec_ok) begin
                dlr_q <= {2'b10, data_x};
              end else begin
                dlr_q <= {2'b00, data_x};
                if (key_en) begin
                  for (int s = 0; s < NUM_KEYS; s++) begin
                    if (slot_hit[s]) begin
                      fail_cnt[s] <= cnt_next;
                      if (cnt_next == MAX_CNT) lock[s] <= 1'b1;
                    end
                  end
                end
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_dlr_e = dlr_q;
  assign bus.o_dhr_e = dhr_q;
  assign bus.o_lock  = lock;
endmodule

// File: tb/tb_ex_mod_krr_keyring.sv
// Self-checking bench for ex_mod_krr_keyring: directed scenarios plus randomized ops,
// all checked against an array-based reference model of the keyring rules.
module tb_ex_mod_krr_keyring;
  // Three slots with a 2-bit select leaves slot index 3 addressable but out of range.
  localparam int DW    = 64;
  localparam int PW    = 16;
  localparam int NK    = 3;
  localparam int MF    = 3;
  localparam int SW    = 2;
  localparam int EXP_W = 1 + 2 * (DW + 2) + NK;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ex_mod_krr_keyring_if #(.DATA_W(DW), .NUM_KEYS(NK), .SLOT_W(SW)) bus ();

  ex_mod_krr_keyring #(
    .DATA_W(DW), .PAR_W(PW), .NUM_KEYS(NK), .MAX_FAIL(MF), .SLOT_W(SW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  logic [DW-1:0]    m_key [NK];
  int               m_cnt [NK];
  logic [NK-1:0]    m_lock;
  logic             last_v;
  logic [DW+1:0]    last_dlr;
  logic [DW+1:0]    last_dhr;
  logic [EXP_W-1:0] exp_q[$];

  function automatic logic [PW-1:0] m_fold(input logic [DW-1:0] x);
    logic [PW-1:0] f;
    logic [DW-1:0] t;
    f = '0;
    t = x;
    while (t != '0) begin
      f = f ^ t[PW-1:0];
      t = t >> PW;
    end
    return f;
  endfunction

  function automatic logic [DW-1:0] m_key_of(input int s);
    return (s < NK) ? m_key[s] : '0;
  endfunction

  // Parity word a correct encoder would have produced for plaintext p under slot s.
  function automatic logic [DW-1:0] good_dhr(input int s, input logic [DW-1:0] p);
    logic [DW-1:0] k;
    k = m_key_of(s);
    return DW'(m_fold(p) ^ k[PW-1:0]);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NK; s++) begin
      m_key[s] = '0;
      m_cnt[s] = 0;
    end
    m_lock   = '0;
    last_v   = 1'b0;
    last_dlr = '0;
    last_dhr = '0;
    exp_q.delete();
  endtask

  // Drives one cycle of inputs, predicts the registered result, then steps one edge.
  task automatic drive_op(input logic valid, input logic hold, input logic [1:0] op,
                          input logic [SW-1:0] slot, input logic [DW-1:0] dlr,
                          input logic [DW-1:0] dhr,
                          output logic [DW+1:0] e_dlr, output logic [DW+1:0] e_dhr);
    logic          ev;
    logic [DW+1:0] ed;
    logic [DW+1:0] eh;
    logic [DW-1:0] k;
    logic [DW-1:0] d;
    logic          in_rng;
    logic          locked;
    logic          en;
    logic          ok;
    int            s;
    bus.i_valid = valid;
    bus.i_hold  = hold;
    bus.i_op    = op;
    bus.i_slot  = slot;
    bus.i_dlr   = dlr;
    bus.i_dhr   = dhr;
    ev = 1'b0;
    ed = '0;
    eh = '0;
    s      = int'(slot);
    in_rng = (s < NK);
    k      = m_key_of(s);
    locked = in_rng ? m_lock[s] : 1'b0;
    if (hold) begin
      ev = last_v;
      ed = last_dlr;
      eh = last_dhr;
    end else if (valid) begin
      ev = 1'b1;
      d  = dlr ^ k;
      en = (k[3:0] != 4'h0);
      ok = en && (m_fold(d) == (dhr[PW-1:0] ^ k[PW-1:0]));
      case (op)
        2'b00: begin
          ed = {2'b00, dlr};
          if (in_rng) begin
            m_key[s] = dlr;
            m_cnt[s] = 0;
            m_lock[s] = 1'b0;
          end
        end
        2'b11: begin
          if (in_rng) begin
            m_key[s] = '0;
            m_cnt[s] = 0;
            m_lock[s] = 1'b0;
          end
        end
        2'b10: begin
          if (!locked) begin
            ed = {2'b00, d};
            eh = (DW+2)'(m_fold(dlr) ^ k[PW-1:0]);
          end
        end
        default: begin
          if (!locked) begin
            if (ok) begin
              ed = {2'b10, d};
            end else begin
              ed = {2'b00, d};
              if (en) begin
                m_cnt[s] = (m_cnt[s] + 1 > MF) ? MF : m_cnt[s] + 1;
                if (m_cnt[s] == MF) m_lock[s] = 1'b1;
              end
            end
          end
        end
      endcase
    end
    exp_q.push_back({ev, ed, eh, m_lock});
    last_v   = ev;
    last_dlr = ed;
    last_dhr = eh;
    e_dlr    = ed;
    e_dhr    = eh;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.o_valid, bus.o_dlr_e, bus.o_dhr_e, bus.o_lock} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b dlr=%h dhr=%h lock=%b required all zero",
               bus.o_valid, bus.o_dlr_e, bus.o_dhr_e, bus.o_lock);
    end
  endtask

  task automatic test_disabled_key();
    logic [DW+1:0] ed, eh;
    logic [EXP_W-1:0] e;
    drive_op(1'b1, 1'b0, 2'b01, 2'd0, 64'h1234, 64'h0, ed, eh);
    e = exp_q.pop_front();
    checks++;
    if ({bus.o_valid, bus.o_dlr_e, bus.o_dhr_e, bus.o_lock} !== e) begin
      errors++;
      $display("FAIL disabled_dec: got %h required %h",
               {bus.o_valid, bus.o_dlr_e, bus.o_dhr_e, bus.o_lock}, e);
    end
    checks++;
    if (bus.o_dlr_e !== {2'b00, 64'h1234}) begin
      errors++;
      $display("FAIL disabled_dec_lit: got %h required %h", bus.o_dlr_e, {2'b00, 64'h1234});
    end
  endtask

  // LDKEY followed directly by ENC exercises back-to-back key visibility.
  task automatic test_enc_dec();
    logic [DW+1:0] ed, eh, lo, hi;
    logic [EXP_W-1:0] e;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive_op(1'b1, 1'b0, 2'b00, 2'd1, 64'hA5A5_0000_0000_0001, 64'h0, ed, eh);
        1: begin
          drive_op(1'b1, 1'b0, 2'b10, 2'd1, 64'hDEAD_BEEF, 64'h0, ed, eh);
          lo = ed;
          hi = eh;
        end
        default: drive_op(1'b1, 1'b0, 2'b01, 2'd1, lo[DW-1:0], hi[DW-1:0], ed, eh);
      endcase
      e = exp_q.pop_front();
      checks++;
      if ({bus.o_valid, bus.o_dlr_e, bus.o_dhr_e, bus.o_lock} !== e) begin
        errors++;
        $display("FAIL enc_dec step %0d: got %h required %h", i,
                 {bus.o_valid, bus.o_dlr_e, bus.o_dhr_e, bus.o_lock}, e);
      end
    end
    checks++;
    if (bus.o_dlr_e !== {2'b10, 64'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL enc_dec_roundtrip: got %h required %h", bus.o_dlr_e, {2'b10, 64'hDEAD_BEEF});
    end
  endtask

  task automatic test_lock();
    logic [DW+1:0] ed, eh;
    logic [EXP_W-1:0] e;
    logic [DW-1:0] p;
    p = 64'h0123_4567_89AB_CDEF;
    drive_op(1'b1, 1'b0, 2'b00, 2'd2, 64'h5A5A_1111_2222_3337, 64'h0, ed, eh);
    void'(exp_q.pop_front());
    for (int i = 0; i < 7; i++) begin
      case (i)
        0, 1, 2: drive_op(1'b1, 1'b0, 2'b01, 2'd1, p ^ m_key_of(1), good_dhr(1, p) ^ 64'h1, ed, eh);
        3: drive_op(1'b1, 1'b0, 2'b01, 2'd1, p ^ m_key_of(1), good_dhr(1, p), ed, eh);
        4: drive_op(1'b1, 1'b0, 2'b10, 2'd1, p, 64'h0, ed, eh);
        5: drive_op(1'b1, 1'b0, 2'b10, 2'd2, p, 64'h0, ed, eh);
        default: drive_op(1'b1, 1'b0, 2'b01, 2'd2, p ^ m_key_of(2), good_dhr(2, p), ed, eh);
      endcase
      e = exp_q.pop_front();
      checks++;
      if ({bus.o_valid, bus.o_dlr_e, bus.o_dhr_e, bus.o_lock} !== e) begin
        errors++;
        $display("FAIL lock step %0d: got %h required %h", i,
                 {bus.o_valid, bus.o_dlr_e, bus.o_dhr_e, bus.o_lock}, e);
      end
      if (i == 2) begin
        checks++;
        if (bus.o_lock[1] !== 1'b1) begin
          errors++;
          $display("FAIL lock_after_third: got %b required 1", bus.o_lock[1]);
        end
      end
    end
    checks++;
    if (bus.o_dlr_e !== {2'b10, p}) begin
      errors++;
      $display("FAIL lock_slot2_unaffected: got %h required %h", bus.o_dlr_e, {2'b10, p});
    end
  endtask

  task automatic test_reload();
    logic [DW+1:0] ed, eh;
    logic [EXP_W-1:0] e;
    logic [DW-1:0] p;
    p = 64'hFEED_F00D_CAFE_0042;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive_op(1'b1, 1'b0, 2'b00, 2'd1, 64'hA5A5_0000_0000_0001, 64'h0, ed, eh);
      else        drive_op(1'b1, 1'b0, 2'b01, 2'd1, p ^ m_key_of(1), good_dhr(1, p), ed, eh);
      e = exp_q.pop_front();
      checks++;
      if ({bus.o_valid, bus.o_dlr_e, bus.o_dhr_e, bus.o_lock} !== e) begin
        errors++;
        $display("FAIL reload step %0d: got %h required %h", i,
                 {bus.o_valid, bus.o_dlr_e, bus.o_dhr_e, bus.o_lock}, e);
      end
    end
    checks++;
    if (bus.o_dlr_e !== {2'b10, p} || bus.o_lock[1] !== 1'b0) begin
      errors++;
      $display("FAIL reload_dec: got dlr=%h lock1=%b required dlr=%h lock1=0",
               bus.o_dlr_e, bus.o_lock[1], {2'b10, p});
    end
  endtask

  task automatic test_hold();
    logic [DW+1:0] ed, eh;
    logic [EXP_W-1:0] e;
    logic [DW-1:0] p;
    p = 64'h1357_9BDF_2468_ACE0;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0, 1: drive_op(1'b1, 1'b1, 2'b10, 2'd1, p, 64'h0, ed, eh);
        2: drive_op(1'b1, 1'b1, 2'b00, 2'd1, 64'hFFFF_0000_0000_0003, 64'h0, ed, eh);
        3: drive_op(1'b1, 1'b1, 2'b01, 2'd1, 64'h0, 64'h0, ed, eh);
        4: drive_op(1'b1, 1'b0, 2'b10, 2'd1, p, 64'h0, ed, eh);
        5: drive_op(1'b0, 1'b0, 2'b10, 2'd1, p, 64'h0, ed, eh);
        default: drive_op(1'b1, 1'b0, 2'b01, 2'd1, p ^ m_key_of(1), good_dhr(1, p), ed, eh);
      endcase
      e = exp_q.pop_front();
      checks++;
      if ({bus.o_valid, bus.o_dlr_e, bus.o_dhr_e, bus.o_lock} !== e) begin
        errors++;
        $display("FAIL hold step %0d: got %h required %h", i,
                 {bus.o_valid, bus.o_dlr_e, bus.o_dhr_e, bus.o_lock}, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW+1:0] ed, eh;
    logic [EXP_W-1:0] e;
    logic [DW-1:0] k, p;
    for (int i = 0; i < 8; i++) begin
      k = {$urandom, $urandom} | 64'h1;
      p = {$urandom, $urandom};
      drive_op(1'b1, 1'b0, 2'b00, 2'(i % NK), k, 64'h0, ed, eh);
      void'(exp_q.pop_front());
      drive_op(1'b1, 1'b0, 2'b01, 2'(i % NK), p ^ k, good_dhr(i % NK, p), ed, eh);
      e = exp_q.pop_front();
      checks++;
      if ({bus.o_valid, bus.o_dlr_e, bus.o_dhr_e, bus.o_lock} !== e || bus.o_dlr_e !== {2'b10, p}) begin
        errors++;
        $display("FAIL back_to_back %0d: got %h required %h", i,
                 {bus.o_valid, bus.o_dlr_e, bus.o_dhr_e, bus.o_lock}, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW+1:0] ed, eh;
    logic [EXP_W-1:0] e;
    logic [DW-1:0] p;
    p = 64'hAAAA_5555_0F0F_F0F0;
    drive_op(1'b1, 1'b0, 2'b00, 2'd2, 64'h0000_0000_0000_0009, 64'h0, ed, eh);
    for (int i = 0; i < MF; i++) begin
      drive_op(1'b1, 1'b0, 2'b01, 2'd2, p, good_dhr(2, p ^ m_key_of(2)) ^ 64'h2, ed, eh);
    end
    bus.i_valid = 1'b1;
    bus.i_hold  = 1'b0;
    bus.i_op    = 2'b00;
    bus.i_slot  = 2'd0;
    bus.i_dlr   = 64'h77;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.o_valid, bus.o_dlr_e, bus.o_dhr_e, bus.o_lock} !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: got v=%b dlr=%h dhr=%h lock=%b required all zero",
               bus.o_valid, bus.o_dlr_e, bus.o_dhr_e, bus.o_lock);
    end
    @(posedge clock);
    #1;
    checks++;
    if ({bus.o_valid, bus.o_dlr_e, bus.o_lock} !== '0) begin
      errors++;
      $display("FAIL reset_mid_held: got v=%b dlr=%h lock=%b required all zero",
               bus.o_valid, bus.o_dlr_e, bus.o_lock);
    end
    model_reset();
    reset = 1'b1;
    drive_op(1'b1, 1'b0, 2'b00, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, ed, eh);
    drive_op(1'b1, 1'b0, 2'b01, 2'd3, p, good_dhr(3, p), ed, eh);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      if (i == 1) begin
        checks++;
        if ({bus.o_valid, bus.o_dlr_e, bus.o_dhr_e, bus.o_lock} !== e || bus.o_dlr_e[DW+1:DW] !== 2'b00) begin
          errors++;
          $display("FAIL out_of_range_dec: got %h required %h",
                   {bus.o_valid, bus.o_dlr_e, bus.o_dhr_e, bus.o_lock}, e);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [DW+1:0] ed, eh;
    logic [EXP_W-1:0] e;
    logic [DW-1:0] dlr, dhr;
    logic [1:0] op;
    logic [SW-1:0] slot;
    logic hold, valid;
    for (int i = 0; i < 400; i++) begin
      hold  = ($urandom_range(0, 7) == 0);
      valid = ($urandom_range(0, 7) != 0);
      op    = 2'($urandom_range(0, 3));
      slot  = SW'($urandom_range(0, 3));
      dlr   = {$urandom, $urandom};
      if (op == 2'b00 && $urandom_range(0, 3) == 0) dlr[3:0] = 4'h0;
      dhr   = ($urandom_range(0, 1) == 1) ? good_dhr(int'(slot), dlr ^ m_key_of(int'(slot)))
                                          : {$urandom, $urandom};
      drive_op(valid, hold, op, slot, dlr, dhr, ed, eh);
      e = exp_q.pop_front();
      checks++;
      if ({bus.o_valid, bus.o_dlr_e, bus.o_dhr_e, bus.o_lock} !== e) begin
        errors++;
        $display("FAIL random step %0d op=%0d slot=%0d hold=%b: got %h required %h", i, op, slot, hold,
                 {bus.o_valid, bus.o_dlr_e, bus.o_dhr_e, bus.o_lock}, e);
      end
    end
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_hold  = 1'b0;
    bus.i_op    = 2'b00;
    bus.i_slot  = '0;
    bus.i_dlr   = '0;
    bus.i_dhr   = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    test_reset();
    test_disabled_key();
    test_enc_dec();
    test_lock();
    test_reload();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
